// File: rtl/mux_pkg.sv
// Shared types and helpers for the scanning N-channel mux.
// Holds the mode enum and the channel wrap function.
package mux_pkg;

  typedef enum logic {
    MANUAL = 1'b0,
    SCAN   = 1'b1
  } mux_mode_t;

  // Next channel index, wrapping n-1 back to 0.
  function automatic int unsigned next_ch(
    input int unsigned cur,
    input int unsigned n
  );
    return (cur + 1 >= n) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/dwell_counter.sv
// Counts enabled cycles; tc is high while the count sits on DWELL-1.
// Ports: clk, rst (async high), en, clr (sync clear), tc.
module dwell_counter #(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tc = (cnt_q == CW'(DWELL - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      if (clr || tc) cnt_d = '0;
      else           cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mux_n_scan.sv
// Registered N-channel mux with manual select or round-robin scan.
// Ports: clk, rst, data_in, sel, mode, en -> y, ch, valid, step, sel_err.
module mux_n_scan
  import mux_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 4,
  parameter  int DWELL    = 4,
  localparam int SELW     = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic [SELW-1:0]           sel,
  input  logic                      mode,
  input  logic                      en,
  output logic [WIDTH-1:0]          y,
  output logic [SELW-1:0]           ch,
  output logic                      valid,
  output logic                      step,
  output logic                      sel_err
);

  mux_mode_t        state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [SELW-1:0]  ch_q, ch_d;
  logic             valid_q, valid_d;
  logic             step_q, step_d;
  logic             err_q, err_d;
  logic             clr;
  logic             tc;
  logic             sel_ok;
  logic [SELW-1:0]  nxt;

  // Out-of-range indices fall through to zero rather than
  // reaching past the bus.
  function automatic logic [WIDTH-1:0] pick(
    input logic [CHANNELS*WIDTH-1:0] d,
    input logic [SELW-1:0]           idx
  );
    logic [WIDTH-1:0] r;
    r = '0;
    for (int k = 0; k < CHANNELS; k++)
      if (idx == SELW'(k)) r = d[k*WIDTH +: WIDTH];
    return r;
  endfunction

  assign sel_ok = (32'(sel) < CHANNELS);
  assign nxt    = SELW'(next_ch(32'(ch_q), CHANNELS));

  dwell_counter #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .clr (clr),
    .tc  (tc)
  );

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    ch_d    = ch_q;
    valid_d = 1'b0;
    step_d  = 1'b0;
    err_d   = err_q;
    clr     = 1'b0;
    if (en) begin
      valid_d = 1'b1;
      if (!mode) begin
        state_d = MANUAL;
        clr     = 1'b1;
        err_d   = !sel_ok;
        ch_d    = sel_ok ? sel : '0;
        y_d     = sel_ok ? pick(data_in, sel) : '0;
      end else if (state_q == MANUAL) begin
        state_d = SCAN;
        clr     = 1'b1;
        err_d   = 1'b0;
        ch_d    = sel_ok ? sel : '0;
        y_d     = pick(data_in, ch_d);
      end else if (tc) begin
        ch_d   = nxt;
        y_d    = pick(data_in, nxt);
        step_d = 1'b1;
      end else begin
        y_d = pick(data_in, ch_q);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MANUAL;
      y_q     <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      step_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      step_q  <= step_d;
      err_q   <= err_d;
    end
  end

  assign y       = y_q;
  assign ch      = ch_q;
  assign valid   = valid_q;
  assign step    = step_q;
  assign sel_err = err_q;

endmodule

// File: tb/tb_mux_n_scan.sv
// Directed bench for mux_n_scan: a 4-ch/dwell-4 instance
// and a 3-ch/dwell-1 instance for the odd-count edge cases.
module tb_mux_n_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [31:0] da = '0;
  logic [1:0]  sela = '0;
  logic        modea = 1'b0;
  logic        ena = 1'b0;
  logic [7:0]  ya;
  logic [1:0]  cha;
  logic        va, sta, ea;

  logic [23:0] db = '0;
  logic [1:0]  selb = '0;
  logic        modeb = 1'b0;
  logic        enb = 1'b0;
  logic [7:0]  yb;
  logic [1:0]  chb;
  logic        vb, stb, eb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_n_scan #(
    .WIDTH    (8),
    .CHANNELS (4),
    .DWELL    (4)
  ) dut_a (
    .clk     (clk),
    .rst     (rst),
    .data_in (da),
    .sel     (sela),
    .mode    (modea),
    .en      (ena),
    .y       (ya),
    .ch      (cha),
    .valid   (va),
    .step    (sta),
    .sel_err (ea)
  );

  mux_n_scan #(
    .WIDTH    (8),
    .CHANNELS (3),
    .DWELL    (1)
  ) dut_b (
    .clk     (clk),
    .rst     (rst),
    .data_in (db),
    .sel     (selb),
    .mode    (modeb),
    .en      (enb),
    .y       (yb),
    .ch      (chb),
    .valid   (vb),
    .step    (stb),
    .sel_err (eb)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(
    input string      tag,
    input logic [7:0] y,
    input logic [1:0] c,
    input logic       v,
    input logic       s
  );
    check({tag, ".y"}, 32'(ya), 32'(y));
    check({tag, ".ch"}, 32'(cha), 32'(c));
    check({tag, ".valid"}, 32'(va), 32'(v));
    check({tag, ".step"}, 32'(sta), 32'(s));
  endtask

  initial begin
    #3;
    chk_a("rst0", 8'h00, 2'd0, 1'b0, 1'b0);
    check("rst0.err", 32'(ea), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Manual select
    da    = {8'h44, 8'h33, 8'h22, 8'h11};
    ena   = 1'b1;
    sela  = 2'd2;
    tick();
    chk_a("man2", 8'h33, 2'd2, 1'b1, 1'b0);
    check("man2.err", 32'(ea), 32'd0);
    sela = 2'd1;
    tick();
    chk_a("man1", 8'h22, 2'd1, 1'b1, 1'b0);

    // Scan from channel 3
    modea = 1'b1;
    sela  = 2'd3;
    tick();
    chk_a("scan_in", 8'h44, 2'd3, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_a("dwell3", 8'h44, 2'd3, 1'b1, 1'b0);
    end
    tick();
    chk_a("wrap0", 8'h11, 2'd0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_a("dwell0", 8'h11, 2'd0, 1'b1, 1'b0);
    end
    tick();
    chk_a("adv1", 8'h22, 2'd1, 1'b1, 1'b1);
    tick();
    chk_a("ch1c1", 8'h22, 2'd1, 1'b1, 1'b0);

    // Freeze mid-dwell
    ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_a("hold", 8'h22, 2'd1, 1'b0, 1'b0);
    end

    // Live data on the current channel
    da[15:8] = 8'hA5;
    ena      = 1'b1;
    tick();
    chk_a("live", 8'hA5, 2'd1, 1'b1, 1'b0);
    tick();
    chk_a("live2", 8'hA5, 2'd1, 1'b1, 1'b0);
    tick();
    chk_a("adv2", 8'h33, 2'd2, 1'b1, 1'b1);

    // Async reset mid-scan
    #2;
    rst = 1'b1;
    #1;
    chk_a("rst_async", 8'h00, 2'd0, 1'b0, 1'b0);
    check("rst_async.err", 32'(ea), 32'd0);
    @(negedge clk);
    rst   = 1'b0;
    modea = 1'b0;
    sela  = 2'd0;
    tick();
    chk_a("post_rst", 8'h11, 2'd0, 1'b1, 1'b0);

    // Three channels: bad select, then scan entry
    db    = {8'h0C, 8'h0B, 8'h0A};
    enb   = 1'b1;
    modeb = 1'b0;
    selb  = 2'd3;
    tick();
    check("b_bad.y", 32'(yb), 32'h00);
    check("b_bad.ch", 32'(chb), 32'd0);
    check("b_bad.err", 32'(eb), 32'd1);
    check("b_bad.valid", 32'(vb), 32'd1);
    enb = 1'b0;
    tick();
    check("b_hold.err", 32'(eb), 32'd1);
    check("b_hold.valid", 32'(vb), 32'd0);
    enb   = 1'b1;
    modeb = 1'b1;
    tick();
    check("b_scan.ch", 32'(chb), 32'd0);
    check("b_scan.y", 32'(yb), 32'h0A);
    check("b_scan.err", 32'(eb), 32'd0);
    check("b_scan.step", 32'(stb), 32'd0);
    tick();
    check("b_s1.ch", 32'(chb), 32'd1);
    check("b_s1.y", 32'(yb), 32'h0B);
    check("b_s1.step", 32'(stb), 32'd1);
    tick();
    check("b_s2.ch", 32'(chb), 32'd2);
    check("b_s2.y", 32'(yb), 32'h0C);
    tick();
    check("b_wrap.ch", 32'(chb), 32'd0);
    check("b_wrap.y", 32'(yb), 32'h0A);
    check("b_wrap.step", 32'(stb), 32'd1);
    modeb = 1'b0;
    selb  = 2'd2;
    tick();
    check("b_man.ch", 32'(chb), 32'd2);
    check("b_man.y", 32'(yb), 32'h0C);
    check("b_man.step", 32'(stb), 32'd0);
    check("b_man.err", 32'(eb), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
